bft_stream_tx: RTL and testbench
================================

BFT_STREAM_TX -- requirements
Module: bft_stream_tx

Interface
REQ-001 The block SHALL have parameter PACKET_BITS, default 49, meaning BFT packet width.
REQ-002 The block SHALL have parameter PAYLOAD_BITS, default 32, meaning data payload width.
REQ-003 The block SHALL have parameter NUM_LEAF_BITS, default 5, meaning leaf address field width.
REQ-004 The block SHALL have parameter NUM_PORT_BITS, default 4, meaning port field width.
REQ-005 The block SHALL have parameter NUM_ADDR_BITS, default 7, meaning addr/sequence field width.
REQ-006 The block SHALL have parameter NUM_BRAM_ADDR_BITS, default 7, meaning the log2 of the remote buffer depth.
REQ-007 The block SHALL have parameter SELF_LEAF, default 0, meaning the leaf address of this sender, used for credit matching.
REQ-008 The block SHALL use one clock and a synchronous, active-high reset: clk (input, 1 bit) is the single clock, and reset (input, 1 bit) is the synchronous active-high reset.
REQ-009 The block SHALL have port din (input, PAYLOAD_BITS) carrying the user payload.
REQ-010 The block SHALL have ports vld_in (input, 1), meaning payload valid, and ack_out (output, 1), meaning payload accepted this cycle.
REQ-011 The block SHALL have ports dest_leaf (input, NUM_LEAF_BITS) and dest_port (input, NUM_PORT_BITS), both sampled with each accepted payload.
REQ-012 The block SHALL have port din_bft2tx (input, PACKET_BITS), carrying returned credit packets.
REQ-013 The block SHALL have port dout_tx2bft (output, PACKET_BITS), carrying outgoing packets.
REQ-014 The block SHALL have port resend (input, 1), meaning network replay in progress, during which the block pauses.
REQ-015 The block SHALL have port credits (output, NUM_BRAM_ADDR_BITS+1), carrying the current credit count.

Function
REQ-016 Packet layout SHALL be: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload; a packet with valid=0 is idle.
REQ-017 A transfer SHALL occur when vld_in and ack_out are both high; the transfer SHALL appear on dout_tx2bft exactly 1 cycle later, for exactly 1 cycle, from a register.
REQ-018 ack_out SHALL equal (state==SEND) and not resend, combinationally.
REQ-019 FSM states SHALL be STALL (credits==0), SEND (credits>0), and HOLD (resend high); HOLD SHALL take priority, otherwise the state SHALL be selected by the credit count next cycle.
REQ-020 A credit packet SHALL be din_bft2tx with valid=1, leaf==SELF_LEAF and port==0; its increment SHALL be payload[NUM_BRAM_ADDR_BITS:0]; all other packets SHALL be ignored.
REQ-021 Each transfer SHALL consume 1 credit; a simultaneous credit and transfer SHALL yield credits+inc-1 in the same cycle.
REQ-022 credits SHALL saturate at 2^NUM_BRAM_ADDR_BITS (128) and SHALL never underflow.
REQ-023 When credits==1 and a transfer occurs with no credit arriving, ack_out SHALL be low from the next cycle.
REQ-024 While resend is high, dout_tx2bft SHALL be forced to 0 combinationally, including a pending registered packet; that packet SHALL be lost, and the credit consumed for it SHALL NOT be refunded.
REQ-025 Credit packets SHALL still be counted while resend is high.

Reset
REQ-026 On reset, dout_tx2bft SHALL be 0, ack_out SHALL be 0, credits SHALL be 128, the sequence counter SHALL be 0, and the state SHALL be SEND, with ack_out high in the first cycle after reset deasserts.
REQ-027 Reset asserted mid-transfer SHALL discard the registered packet in the next cycle.

Configuration
REQ-028 With BFT_TX_SEQ_EN defined, the addr field SHALL carry a 7-bit sequence number that increments per transfer and wraps 127->0; without it, the addr field SHALL be 0 and no counter SHALL exist.

Structure
REQ-029 Package bft_pkg SHALL hold the field offset/width constants, the credit-port constant (0), and the FSM state typedef.
REQ-030 Credit arithmetic SHALL live in sub-module bft_credit_counter (inputs: inc, inc_vld, dec; output: count).

Verification
REQ-031 After reset, push 3 words 0xA,0xB,0xC to leaf 3, port 2 -> 3 consecutive packets appear 1 cycle later with valid=1, leaf=3, port=2, and credits reads 125.
REQ-032 Push 128 words with no credit return -> ack_out is low on the 129th cycle, the state is STALL, and dout_tx2bft is idle.
REQ-033 In STALL, inject a credit packet (leaf=SELF_LEAF, port=0, payload=64) -> credits reads 64 and ack_out is high next cycle.
REQ-034 Inject a credit of 64 and a transfer in the same cycle with credits=100 -> credits reads 128 (saturated), then 127 after the next transfer.
REQ-035 Assert resend for 5 cycles during a stream -> dout_tx2bft is 0 and ack_out is 0 throughout, and traffic resumes afterwards.
REQ-036 With BFT_TX_SEQ_EN defined, send 130 words with credits replenished -> the addr field runs 0..127,0,1.

Source files
------------

// File: rtl/bft_pkg.sv
// BFT stream transmitter shared definitions: default packet field layout,
// the credit return port number, and the transmitter FSM state type.
package bft_pkg;

    // Default 49-bit packet layout: [48] valid, [47:43] leaf, [42:39] port,
    // [38:32] addr/sequence, [31:0] payload.
    localparam int unsigned PKT_VALID_BIT = 48;
    localparam int unsigned PKT_LEAF_LSB  = 43;
    localparam int unsigned PKT_LEAF_W    = 5;
    localparam int unsigned PKT_PORT_LSB  = 39;
    localparam int unsigned PKT_PORT_W    = 4;
    localparam int unsigned PKT_ADDR_LSB  = 32;
    localparam int unsigned PKT_ADDR_W    = 7;
    localparam int unsigned PKT_DATA_LSB  = 0;
    localparam int unsigned PKT_DATA_W    = 32;

    // Credits come back on this port of the sender's own leaf.
    localparam int unsigned CREDIT_PORT = 0;

    typedef enum logic [1:0] {
        STALL = 2'd0,
        SEND  = 2'd1,
        HOLD  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/bft_credit_counter.sv
// Saturating credit counter for the BFT transmitter. Resets full
// (2^NUM_BRAM_ADDR_BITS), adds returned credits, subtracts one per transfer,
// never underflows. count_next exposes the value being loaded this cycle so
// the FSM can pick its next state from the post-update credit count.
module bft_credit_counter
    import bft_pkg::*;
#(
    parameter int unsigned NUM_BRAM_ADDR_BITS = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_BRAM_ADDR_BITS:0]   inc,
    input  logic                          inc_vld,
    input  logic                          dec,
    output logic [NUM_BRAM_ADDR_BITS:0]   count,
    output logic [NUM_BRAM_ADDR_BITS:0]   count_next
);

    // One extra bit of headroom so count + inc cannot wrap before saturation.
    localparam logic [NUM_BRAM_ADDR_BITS+1:0] W_MAX = {2'b01, {NUM_BRAM_ADDR_BITS{1'b0}}};
    localparam logic [NUM_BRAM_ADDR_BITS+1:0] W_ONE = {{(NUM_BRAM_ADDR_BITS+1){1'b0}}, 1'b1};
    localparam logic [NUM_BRAM_ADDR_BITS:0]   W_FULL = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};

    logic [NUM_BRAM_ADDR_BITS:0]   r_count;
    logic [NUM_BRAM_ADDR_BITS+1:0] w_sum;
    logic [NUM_BRAM_ADDR_BITS+1:0] w_net;

    // Add incoming credit, take one for a transfer (floored at 0), then saturate.
    always_comb begin
        w_sum = {1'b0, r_count} + (inc_vld ? {1'b0, inc} : '0);
        w_net = w_sum;
        if (dec && (w_sum != '0)) begin
            w_net = w_sum - W_ONE;
        end
        count_next = (w_net > W_MAX) ? W_FULL : w_net[NUM_BRAM_ADDR_BITS:0];
    end

    // Credit register, full on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= W_FULL;
        end else begin
            r_count <= count_next;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/bft_stream_tx.sv
// BFT stream transmitter: accepts payload words under credit-based flow
// control and emits registered BFT packets one cycle after acceptance.
// Credit packets returned on din_bft2tx replenish the credit count.
// Optional feature: define BFT_TX_SEQ_EN to carry a per-transfer sequence
// number in the addr field; otherwise the addr field is 0.
module bft_stream_tx
    import bft_pkg::*;
#(
    parameter int unsigned PACKET_BITS        = 49,
    parameter int unsigned PAYLOAD_BITS       = 32,
    parameter int unsigned NUM_LEAF_BITS      = 5,
    parameter int unsigned NUM_PORT_BITS      = 4,
    parameter int unsigned NUM_ADDR_BITS      = 7,
    parameter int unsigned NUM_BRAM_ADDR_BITS = 7,
    parameter int unsigned SELF_LEAF          = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PAYLOAD_BITS-1:0]       din,
    input  logic                          vld_in,
    output logic                          ack_out,
    input  logic [NUM_LEAF_BITS-1:0]      dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]      dest_port,
    input  logic [PACKET_BITS-1:0]        din_bft2tx,
    output logic [PACKET_BITS-1:0]        dout_tx2bft,
    input  logic                          resend,
    output logic [NUM_BRAM_ADDR_BITS:0]   credits
);

    localparam int unsigned PORT_LSB  = PAYLOAD_BITS + NUM_ADDR_BITS;
    localparam int unsigned LEAF_LSB  = PORT_LSB + NUM_PORT_BITS;
    localparam int unsigned VALID_BIT = LEAF_LSB + NUM_LEAF_BITS;

    tx_state_t                     r_state;
    tx_state_t                     w_state_next;
    logic [PACKET_BITS-1:0]        r_pkt;
    logic [NUM_ADDR_BITS-1:0]      w_addr;
    logic                          w_xfer;
    logic                          w_credit_vld;
    logic [NUM_BRAM_ADDR_BITS:0]   w_inc;
    logic [NUM_BRAM_ADDR_BITS:0]   w_credits_next;

    assign w_credit_vld = din_bft2tx[VALID_BIT]
                       && (din_bft2tx[LEAF_LSB +: NUM_LEAF_BITS] == NUM_LEAF_BITS'(SELF_LEAF))
                       && (din_bft2tx[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(CREDIT_PORT));
    assign w_inc        = din_bft2tx[NUM_BRAM_ADDR_BITS:0];

    assign ack_out = (r_state == SEND) && !resend && !reset;
    assign w_xfer  = vld_in && ack_out;

    bft_credit_counter #(
        .NUM_BRAM_ADDR_BITS (NUM_BRAM_ADDR_BITS)
    ) u_credit (
        .clk        (clk),
        .reset      (reset),
        .inc        (w_inc),
        .inc_vld    (w_credit_vld),
        .dec        (w_xfer),
        .count      (credits),
        .count_next (w_credits_next)
    );

`ifdef BFT_TX_SEQ_EN
    logic [NUM_ADDR_BITS-1:0] r_seq;

    // Sequence number advances once per accepted word, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq <= '0;
        end else if (w_xfer) begin
            r_seq <= r_seq + NUM_ADDR_BITS'(1);
        end
    end

    assign w_addr = r_seq;
`else
    assign w_addr = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEND;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: replay pause wins, else follow the post-update credit count
    // so the last credit closes ack_out on the very next cycle.
    always_comb begin
        w_state_next = SEND;
        if (resend) begin
            w_state_next = HOLD;
        end else if (w_credits_next == '0) begin
            w_state_next = STALL;
        end
    end

    // Output packet register: holds an accepted word for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt <= '0;
        end else if (w_xfer) begin
            r_pkt <= {1'b1, dest_leaf, dest_port, w_addr, din};
        end else begin
            r_pkt <= '0;
        end
    end

    assign dout_tx2bft = resend ? '0 : r_pkt;

endmodule

// File: tb/tb_bft_stream_tx.sv
// Self-checking bench for bft_stream_tx: a driver issues directed and random
// stimulus and pushes expected packets into a scoreboard; a monitor on the
// falling edge pops and compares whatever the DUT presents.
// Build with +define+BFT_TX_SEQ_EN to exercise the sequence-number variant.
module tb_bft_stream_tx;

    localparam int unsigned SELF = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        vld_in;
    logic        ack_out;
    logic [4:0]  dest_leaf;
    logic [3:0]  dest_port;
    logic [48:0] din_bft2tx;
    logic [48:0] dout_tx2bft;
    logic        resend;
    logic [7:0]  credits;

    always #5 clk = ~clk;

    bft_stream_tx #(
        .PACKET_BITS        (49),
        .PAYLOAD_BITS       (32),
        .NUM_LEAF_BITS      (5),
        .NUM_PORT_BITS      (4),
        .NUM_ADDR_BITS      (7),
        .NUM_BRAM_ADDR_BITS (7),
        .SELF_LEAF          (SELF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .vld_in      (vld_in),
        .ack_out     (ack_out),
        .dest_leaf   (dest_leaf),
        .dest_port   (dest_port),
        .din_bft2tx  (din_bft2tx),
        .dout_tx2bft (dout_tx2bft),
        .resend      (resend),
        .credits     (credits)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [48:0] pkt;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Reference model: credit pool, one-cycle replay hangover, sequence count.
    int m_credits = 128;
    bit m_prev_rs = 1'b0;
    int m_seq     = 0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    function automatic logic [48:0] npkt(input bit v, input logic [4:0] lf,
                                         input logic [3:0] pt, input logic [31:0] pl);
        return {v, lf, pt, 7'd0, pl};
    endfunction

    function automatic logic [6:0] exp_addr();
`ifdef BFT_TX_SEQ_EN
        return 7'(m_seq);
`else
        return 7'd0;
`endif
    endfunction

    // One clock of stimulus; checks ack/credits against the model mid-cycle.
    task automatic step(input bit rst, input bit vld, input logic [31:0] d,
                        input logic [4:0] lf, input logic [3:0] pt,
                        input logic [48:0] net, input bit rs);
        bit exp_ack;
        bit xfer;
        int inc;
        int c;
        reset = rst; vld_in = vld; din = d; dest_leaf = lf; dest_port = pt;
        din_bft2tx = net; resend = rs;
        @(negedge clk);
        exp_ack = !rst && !rs && !m_prev_rs && (m_credits > 0);
        chk("ack_out", ack_out, exp_ack);
        chk("credits", credits, m_credits);
        xfer = vld && exp_ack;
        if (xfer) sb.push_back('{pkt: {1'b1, lf, pt, exp_addr(), d}, due: cyc + 1});
        @(posedge clk); #1;
        if (rst) begin
            m_credits = 128; m_seq = 0; m_prev_rs = 1'b0;
        end else begin
            inc = (net[48] && net[47:43] == 5'(SELF) && net[42:39] == 4'd0) ? int'(net[7:0]) : 0;
            c = m_credits + inc - (xfer ? 1 : 0);
            m_credits = (c > 128) ? 128 : c;
            m_prev_rs = rs;
            if (xfer) m_seq = (m_seq + 1) % 128;
        end
    endtask

    task automatic idle(input bit rst);
        step(rst, 1'b0, 32'd0, 5'd0, 4'd0, 49'd0, 1'b0);
    endtask

    task automatic word(input logic [31:0] d, input logic [48:0] net, input bit rs);
        step(1'b0, 1'b1, d, 5'd3, 4'd2, net, rs);
    endtask

    // Monitor: compare whenever a packet is due or the DUT shows one.
    always @(negedge clk) begin
        logic [48:0] exp_pkt;
        if (mon_en) begin
            exp_pkt = '0;
            while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_pkt = resend ? 49'd0 : sb[0].pkt;
                void'(sb.pop_front());
            end
            if (exp_pkt != '0 || dout_tx2bft != '0) chk("dout_tx2bft", dout_tx2bft, exp_pkt);
        end
    end

    initial begin
        logic [48:0] net;
        int r;
        reset = 1'b1; vld_in = 1'b0; din = '0; dest_leaf = '0; dest_port = '0;
        din_bft2tx = '0; resend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset state, then three words to leaf 3 port 2.
        repeat (3) idle(1'b1);
        chk("reset_dout", dout_tx2bft, 0);
        idle(1'b0);
        word(32'hA, '0, 1'b0);
        word(32'hB, '0, 1'b0);
        word(32'hC, '0, 1'b0);
        chk("credits_after_3", credits, 125);
        idle(1'b0);

        // Exhaust all credits with no return.
        repeat (2) idle(1'b1);
        for (int i = 0; i < 130; i++) word(32'(i), '0, 1'b0);
        chk("stall_ack", ack_out, 0);
        chk("stall_credits", credits, 0);
        idle(1'b0);

        // Credit return while stalled; ignored look-alikes must not count.
        step(1'b0, 1'b0, '0, '0, '0, npkt(1'b1, 5'd0, 4'd0, 32'd64), 1'b0);
        chk("credit64", credits, 64);
        chk("ack_after_credit", ack_out, 1);
        step(1'b0, 1'b0, '0, '0, '0, npkt(1'b1, 5'd1, 4'd0, 32'd9), 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, npkt(1'b1, 5'd0, 4'd1, 32'd9), 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, npkt(1'b0, 5'd0, 4'd0, 32'd9), 1'b0);
        chk("ignored_credits", credits, 64);

        // Simultaneous credit and transfer saturate at 128.
        step(1'b0, 1'b0, '0, '0, '0, npkt(1'b1, 5'd0, 4'd0, 32'd36), 1'b0);
        word(32'h1234, npkt(1'b1, 5'd0, 4'd0, 32'd64), 1'b0);
        chk("saturate", credits, 128);
        word(32'h5678, '0, 1'b0);
        chk("after_sat", credits, 127);

        // Replay pause mid-stream, with a credit counted during it.
        for (int i = 0; i < 3; i++) word(32'h100 + i, '0, 1'b0);
        for (int i = 0; i < 5; i++) word(32'h200 + i, (i == 2) ? npkt(1'b1, 5'd0, 4'd0, 32'd1) : '0, 1'b1);
        for (int i = 0; i < 4; i++) word(32'h300 + i, '0, 1'b0);

        // Reset right after a transfer drops the stream cleanly.
        word(32'hDEAD, '0, 1'b0);
        step(1'b1, 1'b1, 32'hBEEF, 5'd3, 4'd2, '0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // 130 words with one credit back per word: addr field wraps if enabled.
        for (int i = 0; i < 130; i++) word(32'hC000 + i, npkt(1'b1, 5'd0, 4'd0, 32'd1), 1'b0);
        chk("seq_credits", credits, 128);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 15));
            case (r)
                0, 1, 2: net = npkt(1'b1, 5'(SELF), 4'd0, $urandom_range(0, 40) | ($urandom() & 32'hFFFF_FF00));
                3:       net = npkt(1'b1, 5'($urandom_range(1, 31)), 4'd0, $urandom());
                4:       net = npkt(1'b1, 5'(SELF), 4'($urandom_range(1, 15)), $urandom());
                5:       net = npkt(1'b0, 5'(SELF), 4'd0, $urandom());
                default: net = '0;
            endcase
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), $urandom(),
                 5'($urandom()), 4'($urandom()), net, ($urandom_range(0, 29) == 0));
        end

        idle(1'b0);
        idle(1'b0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
